// File: rtl/uint_word_serializer_if.sv
// Valid/ready bundle between the word producer, the serializer and the narrow link.
// The master side drives words in and takes beats out; the slave side is the serializer.
interface uint_word_serializer_if #(
  parameter int WORD_W = 63,
  parameter int BEAT_W = 16
);
  localparam int NUM_BEATS = (WORD_W + BEAT_W - 1) / BEAT_W;
  localparam int IDX_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_bits;
  logic              out_valid;
  logic              out_ready;
  logic [BEAT_W-1:0] out_bits;
  logic [IDX_W-1:0]  out_idx;
  logic              out_last;
  logic              busy;

  modport master (
    output in_valid, in_bits, out_ready,
    input  in_ready, out_valid, out_bits, out_idx, out_last, busy
  );

  modport slave (
    input  in_valid, in_bits, out_ready,
    output in_ready, out_valid, out_bits, out_idx, out_last, busy
  );
endinterface

// File: rtl/uint_word_serializer.sv
// Holds one flat word and emits it as BEAT_W-bit beats, least-significant beat first.
// A new word may be taken on the same cycle the previous word's last beat leaves.
module uint_word_serializer #(
  parameter int WORD_W = 63,
  parameter int BEAT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  uint_word_serializer_if.slave  bus
);
  localparam int NUM_BEATS = (WORD_W + BEAT_W - 1) / BEAT_W;
  localparam int IDX_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int PAD_W     = NUM_BEATS * BEAT_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BEATS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] word_q, word_d;

  logic              out_valid;
  logic              out_last;
  logic              in_ready;
  logic              accept;
  logic              beat_fire;
  logic [PAD_W-1:0]  word_pad;

  assign out_valid = (state_q == SEND);
  assign out_last  = (idx_q == LAST_IDX);
  // Reset gates in_ready directly so upstream never sees a handshake while held in reset.
  assign in_ready  = reset_n && (!out_valid || (bus.out_ready && out_last));
  assign accept    = bus.in_valid && in_ready;
  assign beat_fire = out_valid && bus.out_ready;
  // Zero-extension supplies the padding bits of the final, partial beat.
  assign word_pad  = PAD_W'(word_q);

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    if (accept) begin
      word_d  = bus.in_bits;
      idx_d   = '0;
      state_d = SEND;
    end else if (beat_fire) begin
      if (out_last) begin
        state_d = IDLE;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // NOTE: the word register is reset as well, so out_bits reads 0 during and after reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_bits  = word_pad[idx_q*BEAT_W +: BEAT_W];
  assign bus.out_idx   = idx_q;
  assign bus.out_last  = out_last;
  assign bus.busy      = out_valid;
endmodule

// File: tb/tb_uint_word_serializer.sv
// Directed bench: default 16-bit beats plus a single-beat (BEAT_W=63) instance.
module tb_uint_word_serializer;
  logic clock;
  logic reset_n;
  int   checks;
  int   errors;

  uint_word_serializer_if #(.WORD_W(63), .BEAT_W(16)) b  ();
  uint_word_serializer_if #(.WORD_W(63), .BEAT_W(63)) b1 ();

  uint_word_serializer #(.WORD_W(63), .BEAT_W(16)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (b)
  );

  uint_word_serializer #(.WORD_W(63), .BEAT_W(63)) dut1 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (b1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Packs {busy, valid, last, idx, bits} of the 16-bit instance.
  task automatic chk_beat(input string tag, input logic [15:0] bits, input logic [1:0] idx,
                          input logic last);
    check(tag, 64'({b.busy, b.out_valid, b.out_last, b.out_idx, b.out_bits}),
          64'({1'b1, 1'b1, last, idx, bits}));
  endtask

  task automatic chk_idle(input string tag);
    check(tag, 64'({b.busy, b.out_valid}), 64'd0);
  endtask

  // Presents one word with out_ready=1 and checks its four beats and the idle cycle after.
  task automatic run_word(input string tag, input logic [62:0] w, input logic [15:0] e0,
                          input logic [15:0] e1, input logic [15:0] e2, input logic [15:0] e3);
    logic [15:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    @(negedge clock);
    b.in_valid = 1'b1; b.in_bits = w; b.out_ready = 1'b1;
    #1 check($sformatf("%s_rdy", tag), 64'(b.in_ready), 64'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      b.in_valid = 1'b0;
      #1 chk_beat($sformatf("%s_beat%0d", tag, k), e[k], 2'(k), k == 3);
    end
    @(negedge clock);
    #1 chk_idle($sformatf("%s_idle", tag));
  endtask

  initial begin
    logic [62:0] x [3];
    checks = 0;
    errors = 0;
    b.in_valid = 1'b0;  b.in_bits = '0;  b.out_ready = 1'b0;
    b1.in_valid = 1'b0; b1.in_bits = '0; b1.out_ready = 1'b1;
    reset_n = 1'b0;

    // Reset state
    #2;
    check("rst_valid", 64'({b.out_valid, b.busy}), 64'd0);
    check("rst_in_ready", 64'(b.in_ready), 64'd0);
    check("rst_bits", 64'(b.out_bits), 64'd0);
    check("rst_idx", 64'(b.out_idx), 64'd0);
    @(negedge clock); @(negedge clock);
    reset_n = 1'b1;
    #1 check("rst_rel_in_ready", 64'(b.in_ready), 64'd1);

    // Test 1: basic word, LS beat first
    run_word("t1", 63'h1234_5678_9ABC_DEF0, 16'hDEF0, 16'h9ABC, 16'h5678, 16'h1234);

    // Test 2: in_a field lands in the top beat
    run_word("t2", 63'h7FE0_0000_0000_0000, 16'h0000, 16'h0000, 16'h0000, 16'h7FE0);

    // Padding: all-ones word, bit 15 of the last beat reads 0
    run_word("pad", 63'h7FFF_FFFF_FFFF_FFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h7FFF);

    // Test 3: back-to-back words A=1, B=2 with no bubble
    @(negedge clock);
    b.in_valid = 1'b1; b.in_bits = 63'h1; b.out_ready = 1'b1;
    #1 check("t3_rdy_a", 64'(b.in_ready), 64'd1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      b.in_bits  = 63'h2;
      b.in_valid = (k < 4);
      #1;
      chk_beat($sformatf("t3_beat%0d", k), (k == 0) ? 16'h1 : ((k == 4) ? 16'h2 : 16'h0),
               2'(k % 4), (k % 4) == 3);
      check($sformatf("t3_in_ready%0d", k), 64'(b.in_ready), 64'((k == 3) || (k == 7)));
    end
    @(negedge clock);
    b.in_valid = 1'b0;
    #1 chk_idle("t3_idle");

    // Test 4: backpressure at beat 1; held word must survive a competing in_valid
    @(negedge clock);
    b.in_valid = 1'b1; b.in_bits = 63'h1234_5678_9ABC_DEF0; b.out_ready = 1'b1;
    #1 check("t4_rdy", 64'(b.in_ready), 64'd1);
    @(negedge clock);
    b.in_valid = 1'b0;
    #1 chk_beat("t4_beat0", 16'hDEF0, 2'd0, 1'b0);
    for (int s = 0; s < 3; s++) begin
      @(negedge clock);
      b.out_ready = 1'b0; b.in_valid = 1'b1; b.in_bits = 63'h7FFF_FFFF_FFFF_FFFF;
      #1;
      chk_beat($sformatf("t4_stall%0d", s), 16'h9ABC, 2'd1, 1'b0);
      check($sformatf("t4_stall_rdy%0d", s), 64'(b.in_ready), 64'd0);
    end
    @(negedge clock);
    b.in_valid = 1'b0; b.out_ready = 1'b1;
    #1 chk_beat("t4_beat1", 16'h9ABC, 2'd1, 1'b0);
    @(negedge clock);
    #1 chk_beat("t4_beat2", 16'h5678, 2'd2, 1'b0);
    @(negedge clock);
    #1 chk_beat("t4_beat3", 16'h1234, 2'd3, 1'b1);
    @(negedge clock);
    #1 chk_idle("t4_idle");

    // Test 5: reset after beat 1 drops the word
    @(negedge clock);
    b.in_valid = 1'b1; b.in_bits = 63'h1234_5678_9ABC_DEF0; b.out_ready = 1'b1;
    #1 check("t5_rdy", 64'(b.in_ready), 64'd1);
    @(negedge clock);
    b.in_valid = 1'b0;
    #1 chk_beat("t5_beat0", 16'hDEF0, 2'd0, 1'b0);
    @(negedge clock);
    #1 chk_beat("t5_beat1", 16'h9ABC, 2'd1, 1'b0);
    #1 reset_n = 1'b0;
    #1;
    check("t5_rst_valid", 64'({b.out_valid, b.busy}), 64'd0);
    check("t5_rst_in_ready", 64'(b.in_ready), 64'd0);
    check("t5_rst_bits", 64'(b.out_bits), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    #1 check("t5_rel_in_ready", 64'(b.in_ready), 64'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      #1 chk_idle($sformatf("t5_no_leftover%0d", k));
    end

    // Test 6: single-beat instance streams at full rate
    x[0] = 63'h0123_4567_89AB_CDEF;
    x[1] = 63'h7EDC_BA98_7654_3210;
    x[2] = 63'h5555_AAAA_5555_AAAA;
    @(negedge clock);
    b1.in_valid = 1'b1; b1.in_bits = x[0]; b1.out_ready = 1'b1;
    #1 check("t6_rdy", 64'(b1.in_ready), 64'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      if (k < 2) b1.in_bits = x[k+1];
      else       b1.in_valid = 1'b0;
      #1;
      check($sformatf("t6_ctl%0d", k), 64'({b1.busy, b1.out_valid, b1.out_last, b1.out_idx}),
            64'({1'b1, 1'b1, 1'b1, 1'b0}));
      check($sformatf("t6_bits%0d", k), 64'(b1.out_bits), 64'(x[k]));
      check($sformatf("t6_in_ready%0d", k), 64'(b1.in_ready), 64'd1);
    end
    @(negedge clock);
    #1 check("t6_idle", 64'({b1.busy, b1.out_valid}), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
